// File: rtl/frame_pkg.sv
// Shared definitions for the sine-index frame receiver: broadcast address,
// FSM state encoding, error codes and the frame field slices.
package frame_pkg;

  localparam logic [3:0] BROADCAST_ID = 4'hF;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    PENDING = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_PARITY   = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_OVERRUN  = 2'd2,
    ERR_NO_FRAME = 2'd3
  } err_t;

  // Byte 1 of a frame carries index[11:4].
  function automatic logic [7:0] index_hi(input logic [11:0] index);
    return index[11:4];
  endfunction

  // Byte 2 carries the low index nibble in its upper half.
  function automatic logic [3:0] byte2_lo(input logic [7:0] byte2);
    return byte2[7:4];
  endfunction

  // Byte 2 carries the destination ID in its lower half.
  function automatic logic [3:0] byte2_id(input logic [7:0] byte2);
    return byte2[3:0];
  endfunction

  // Rebuild the 12-bit index from the stored first byte and the second byte.
  function automatic logic [11:0] make_index(input logic [7:0] hi, input logic [7:0] byte2);
    return {hi, byte2_lo(byte2)};
  endfunction

endpackage

// File: rtl/module_frame_receiver_shoot_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Generic enough for any asynchronous strobe; a level held high yields one pulse.
module shoot_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronize the input and register a one-cycle pulse on its rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
      pulse  <= sync_r & ~prev_r;
    end
  end

endmodule

// File: rtl/module_frame_receiver.sv
// Rebuilds two-byte sine-index frames from the UART byte stream, filters on
// this module's ID, stages the frame and commits it on the shared shoot edge.
module module_frame_receiver
  import frame_pkg::*;
#(
  parameter logic [3:0] MODULE_ID    = 4'h1,
  parameter int         BYTE_TIMEOUT = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        parity_error,
  input  logic        shoot,
  output logic [11:0] sin_index,
  output logic [3:0]  frame_id,
  output logic        index_valid,
  output logic        frame_error,
  output logic [1:0]  err_code
);

  localparam int            CW      = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(BYTE_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t      state_r, state_s;
  logic [7:0]  hi_r, hi_s;
  logic [11:0] stg_idx_r, stg_idx_s;
  logic [3:0]  stg_id_r, stg_id_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [11:0] sin_s;
  logic [3:0]  fid_s;
  logic        iv_s, fe_s;
  logic [1:0]  ec_s;
  logic        shoot_edge_s;
  logic        good_s, bad_s, id_ok_s;
  logic        e_par_s, e_to_s, e_ov_s, e_nf_s;

  shoot_sync u_shoot_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (shoot),
    .pulse    (shoot_edge_s)
  );

  assign good_s  = rx_done & ~parity_error;
  assign bad_s   = rx_done & parity_error;
  assign id_ok_s = (byte2_id(rx_data) == MODULE_ID) || (byte2_id(rx_data) == BROADCAST_ID);

  // Next-state, staging, commit and error selection for the frame FSM.
  always_comb begin
    state_s   = state_r;
    hi_s      = hi_r;
    stg_idx_s = stg_idx_r;
    stg_id_s  = stg_id_r;
    cnt_s     = cnt_r;
    sin_s     = sin_index;
    fid_s     = frame_id;
    iv_s      = 1'b0;
    fe_s      = 1'b0;
    ec_s      = err_code;
    e_par_s   = 1'b0;
    e_to_s    = 1'b0;
    e_ov_s    = 1'b0;
    e_nf_s    = 1'b0;

    case (state_r)
      WAIT_HI: begin
        if (good_s) begin
          hi_s    = rx_data;
          cnt_s   = {CW{1'b0}};
          state_s = WAIT_LO;
        end else if (bad_s) begin
          e_par_s = 1'b1;
        end else begin
          state_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
        if (bad_s) begin
          e_par_s = 1'b1;
          state_s = WAIT_HI;
        end else if (good_s) begin
          if (id_ok_s) begin
            stg_idx_s = make_index(hi_r, rx_data);
            stg_id_s  = byte2_id(rx_data);
            state_s   = PENDING;
          end else begin
            state_s   = WAIT_HI;
          end
        end else if (cnt_r == CNT_END) begin
          e_to_s  = 1'b1;
          state_s = WAIT_HI;
        end else begin
          state_s = WAIT_LO;
        end
      end
      PENDING: begin
        if (shoot_edge_s) begin
          // Commit always wins; a byte in the same cycle starts the next frame.
          sin_s = stg_idx_r;
          fid_s = stg_id_r;
          iv_s  = 1'b1;
          if (good_s) begin
            hi_s    = rx_data;
            cnt_s   = {CW{1'b0}};
            state_s = WAIT_LO;
          end else if (bad_s) begin
            e_par_s = 1'b1;
            state_s = WAIT_HI;
          end else begin
            state_s = WAIT_HI;
          end
        end else if (good_s) begin
          e_ov_s  = 1'b1;
          hi_s    = rx_data;
          cnt_s   = {CW{1'b0}};
          state_s = WAIT_LO;
        end else if (bad_s) begin
          // A corrupt byte is reported but leaves the staged frame intact.
          e_par_s = 1'b1;
        end else begin
          state_s = PENDING;
        end
      end
      default: begin
        state_s = WAIT_HI;
      end
    endcase

    if (shoot_edge_s && (state_r != PENDING)) begin
      e_nf_s = 1'b1;
    end else begin
      e_nf_s = 1'b0;
    end

    // Lowest code wins when several errors land in one cycle.
    if (e_par_s) begin
      fe_s = 1'b1;
      ec_s = ERR_PARITY;
    end else if (e_to_s) begin
      fe_s = 1'b1;
      ec_s = ERR_TIMEOUT;
    end else if (e_ov_s) begin
      fe_s = 1'b1;
      ec_s = ERR_OVERRUN;
    end else if (e_nf_s) begin
      fe_s = 1'b1;
      ec_s = ERR_NO_FRAME;
    end else begin
      fe_s = 1'b0;
    end
  end

  // State, staging registers, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= WAIT_HI;
      hi_r        <= 8'h00;
      stg_idx_r   <= 12'h000;
      stg_id_r    <= 4'h0;
      cnt_r       <= {CW{1'b0}};
      sin_index   <= 12'h000;
      frame_id    <= 4'h0;
      index_valid <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      state_r     <= state_s;
      hi_r        <= hi_s;
      stg_idx_r   <= stg_idx_s;
      stg_id_r    <= stg_id_s;
      cnt_r       <= cnt_s;
      sin_index   <= sin_s;
      frame_id    <= fid_s;
      index_valid <= iv_s;
      frame_error <= fe_s;
      err_code    <= ec_s;
    end
  end

endmodule

// File: tb/tb_module_frame_receiver.sv
// Scoreboard bench for module_frame_receiver: stimulus tasks update a
// transaction-level model and queue expected commits/errors with the cycle
// they should appear; an independent monitor pops and compares.
module tb_module_frame_receiver;
  import frame_pkg::*;

  localparam logic [3:0] MID = 4'h1;
  localparam int         T   = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        parity_error = 1'b0;
  logic        shoot = 1'b0;
  logic [11:0] sin_index;
  logic [3:0]  frame_id;
  logic        index_valid;
  logic        frame_error;
  logic [1:0]  err_code;

  module_frame_receiver #(.MODULE_ID(MID), .BYTE_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .parity_error(parity_error), .shoot(shoot), .sin_index(sin_index),
    .frame_id(frame_id), .index_valid(index_valid), .frame_error(frame_error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 commit, 1 error
    logic [11:0] idx;
    logic [3:0]  id;
    logic [1:0]  code;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  // Transaction-level model of the receiver.
  bit          m_hi_v = 1'b0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  int          m_e = 0;
  logic [11:0] m_idx = 12'h000;
  logic [3:0]  m_id = 4'h0;
  logic [11:0] m_last_idx = 12'h000;
  logic [3:0]  m_last_id = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_err(input logic [1:0] c, input int at);
    ev_t e;
    e.kind = 1; e.idx = 12'h000; e.id = 4'h0; e.code = c; e.cyc = at;
    q.push_back(e);
  endfunction

  function automatic void push_commit(input int at);
    ev_t e;
    e.kind = 0; e.idx = m_idx; e.id = m_id; e.code = 2'd0; e.cyc = at;
    q.push_back(e);
    m_last_idx = m_idx;
    m_last_id  = m_id;
  endfunction

  // Model reaction to one received byte sampled at edge d.
  function automatic void model_byte(input logic [7:0] b, input bit par, input int d);
    if (m_pend) begin
      if (par) push_err(2'd0, d);
      else begin
        push_err(2'd2, d);
        m_pend = 1'b0; m_hi_v = 1'b1; m_hi = b; m_e = d;
      end
    end else if (m_hi_v) begin
      m_hi_v = 1'b0;
      if (par) push_err(2'd0, d);
      else if (b[3:0] == MID || b[3:0] == 4'hF) begin
        m_pend = 1'b1; m_idx = {m_hi, b[7:4]}; m_id = b[3:0];
      end
    end else begin
      if (par) push_err(2'd0, d);
      else begin
        m_hi_v = 1'b1; m_hi = b; m_e = d;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit par, input int gap);
    @(negedge clk);
    model_byte(b, par, cyc + 1);
    rx_done = 1'b1; rx_data = b; parity_error = par;
    @(negedge clk);
    rx_done = 1'b0; parity_error = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_shoot(input int w);
    int k;
    @(negedge clk);
    k = cyc + 1;
    if (m_pend) begin
      push_commit(k + 3);
      m_pend = 1'b0;
    end else begin
      push_err(2'd3, k + 3);
    end
    shoot = 1'b1;
    repeat (w) @(negedge clk);
    shoot = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle(input int n);
    int d0;
    @(negedge clk);
    d0 = cyc + 1;
    if (m_hi_v && (m_e + T >= d0 - 1) && (m_e + T <= d0 + n - 1)) begin
      push_err(2'd1, m_e + T);
      m_hi_v = 1'b0;
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi_v = 1'b0; m_pend = 1'b0; m_last_idx = 12'h000; m_last_id = 4'h0;
    check("reset_sin_index", 32'(sin_index), 32'h0);
    check("reset_frame_id", 32'(frame_id), 32'h0);
    check("reset_index_valid", 32'(index_valid), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_err_code", 32'(err_code), 32'h0);
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (index_valid) begin
        if (q.size() == 0) begin
          check("unexpected_commit", 32'(sin_index), 32'hFFFF_FFFF);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("commit_kind", 32'(0), 32'(e.kind));
          check("commit_index", 32'(sin_index), 32'(e.idx));
          check("commit_id", 32'(frame_id), 32'(e.id));
          check("commit_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (frame_error) begin
        if (q.size() == 0) begin
          check("unexpected_error", 32'(err_code), 32'hFFFF_FFFF);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("error_kind", 32'(1), 32'(e.kind));
          check("error_code", 32'(err_code), 32'(e.code));
          check("error_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();

    // Basic frame and commit latency.
    send_byte(8'hAB, 1'b0, 2);
    send_byte(8'hC1, 1'b0, 2);
    do_shoot(3);
    // Foreign ID discarded, then broadcast accepted.
    send_byte(8'h12, 1'b0, 1);
    send_byte(8'h35, 1'b0, 1);
    do_shoot(2);
    send_byte(8'h12, 1'b0, 1);
    send_byte(8'h3F, 1'b0, 1);
    do_shoot(2);
    // Inter-byte timeout, then recovery.
    send_byte(8'h12, 1'b0, 0);
    idle(T + 4);
    send_byte(8'h45, 1'b0, 1);
    send_byte(8'h61, 1'b0, 1);
    do_shoot(4);
    // Corrupt second byte, then shoot with nothing staged.
    send_byte(8'h12, 1'b0, 1);
    send_byte(8'hC1, 1'b1, 1);
    do_shoot(2);
    // Overrun of a staged frame.
    send_byte(8'h11, 1'b0, 1);
    send_byte(8'h21, 1'b0, 1);
    send_byte(8'h22, 1'b0, 1);
    send_byte(8'h31, 1'b0, 1);
    do_shoot(2);
    // Shoot edge and byte in the same cycle while pending.
    send_byte(8'hAB, 1'b0, 1);
    send_byte(8'hC1, 1'b0, 1);
    begin
      int k;
      @(negedge clk);
      k = cyc + 1;
      push_commit(k + 3);
      m_pend = 1'b0; m_hi_v = 1'b1; m_hi = 8'h7F; m_e = k + 3;
      shoot = 1'b1;
      repeat (3) @(negedge clk);
      rx_done = 1'b1; rx_data = 8'h7F;
      @(negedge clk);
      rx_done = 1'b0; shoot = 1'b0;
      check("simul_hi_byte", 32'(dut.hi_r), 32'h7F);
      check("simul_state", 32'(dut.state_r), 32'(WAIT_LO));
      @(negedge clk);
    end
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (m_hi_v && (cyc + 1 - m_e) > T - 20) r = 0;
      if (r <= 11) begin
        logic [7:0] b;
        int sel;
        b = 8'($urandom);
        sel = $urandom_range(0, 3);
        if (sel == 0 || sel == 3) b[3:0] = MID;
        else if (sel == 1) b[3:0] = 4'hF;
        send_byte(b, ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
      end else if (r <= 17) begin
        do_shoot($urandom_range(2, 4));
      end else begin
        idle(T + 4);
      end
    end

    idle(10);
    check("final_queue_empty", 32'(q.size()), 32'h0);
    check("final_sin_index", 32'(sin_index), 32'(m_last_idx));
    check("final_frame_id", 32'(frame_id), 32'(m_last_id));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/module_frame_receiver.md
# module_frame_receiver

Module-side receiver for the inverter's sine-index broadcast. Consumes the byte stream from a `uart_rx` instance and rebuilds each two-byte frame: byte 1 = index[11:4], byte 2 = {index[3:0], id[3:0]}. It filters on this module's ID, holds the frame staged, and commits it to the gate-drive logic on the rising edge of the shared asynchronous `shoot` line. This gives all modules a simultaneous update.

## Interface
- `MODULE_ID`, default 4'h1: this module's 4-bit address. Frames carrying `BROADCAST_ID` (4'hF) are also accepted.
- `BYTE_TIMEOUT`, default 2400: maximum number of clk cycles allowed between byte 1 and byte 2 (100 µs at 24 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rx_done`  in  1  one-cycle strobe from `uart_rx`; `rx_data` is valid in the same cycle.
- `rx_data`  in  8  received byte.
- `parity_error`  in  1  qualifies `rx_done`; high means the byte is corrupt.
- `shoot`  in  1  asynchronous commit line from the master FPGA.
- `sin_index`  out  12  committed sine index. Reset value 0.
- `frame_id`  out  4  ID field of the committed frame. Reset value 0.
- `index_valid`  out  1  one-cycle pulse when `sin_index` updates. Reset value 0.
- `frame_error`  out  1  one-cycle error pulse. Reset value 0.
- `err_code`  out  2  reason for the error, valid while `frame_error` is high; holds its last value otherwise. Reset value 0.
  - 0: parity error.
  - 1: inter-byte timeout.
  - 2: staged frame overwritten before `shoot`.
  - 3: `shoot` arrived with no frame staged.

## Operation
- States: WAIT_HI, WAIT_LO, PENDING. Reset enters WAIT_HI and clears the staging registers and the timeout counter.
- **WAIT_HI**
  - `rx_done` with no parity error: store the byte in `hi_q`, clear the timeout counter, go to WAIT_LO.
  - `rx_done` with parity error: raise error 0 and stay in WAIT_HI.
- **WAIT_LO**
  - The timeout counter increments every cycle.
  - Counter reaches `BYTE_TIMEOUT` - 1 with no byte: raise error 1, go to WAIT_HI.
  - `rx_done` with parity error: raise error 0, go to WAIT_HI.
  - `rx_done` with `rx_data[3:0]` equal to `MODULE_ID` or 4'hF: stage {`hi_q`, `rx_data[7:4]`} and the ID, go to PENDING.
  - `rx_done` with any other ID: discard silently, go to WAIT_HI. This is not an error.
- **PENDING**
  - Synchronized `shoot` rising edge: copy the staged frame to `sin_index`/`frame_id`, pulse `index_valid`, go to WAIT_HI.
  - `rx_done` with a good byte and no `shoot` edge in the same cycle: raise error 2, treat the byte as a new `hi_q`, go to WAIT_LO.
- **Shoot edge outside PENDING:** raise error 3. Outputs stay unchanged. The current state's progress continues.
- **Simultaneous events**
  - In PENDING, a `shoot` edge and `rx_done` in the same cycle: commit first, then take the byte as the new `hi_q`, then go to WAIT_LO. No error 2.
  - Errors 0/1/3 in the same cycle: report the lowest code. Only one `frame_error` pulse is issued per cycle.
- **Reset mid-frame:** the staged frame is lost and `sin_index` returns to 0.

## Timing
- `shoot` passes through a 2-FF synchronizer, then a registered edge detector.
- When `shoot` is first sampled high at edge k, `sin_index` and `index_valid` change at edge k+3.
- A `shoot` pulse must be ≥2 clk cycles wide to be detected. A level held high produces one commit only.
- `rx_done` is consumed the same cycle. The state updates at the next edge.
- `index_valid` and `frame_error` are exactly one cycle wide.
- The timeout counter must be at least $clog2(`BYTE_TIMEOUT`) bits wide and saturates; it never wraps.

## Structure
- **Shared package `frame_pkg`:**
  - `BROADCAST_ID` = 4'hF.
  - The field slices: HI = [11:4], LO nibble = byte2[7:4], ID = byte2[3:0].
  - Err codes `ERR_PARITY`, `ERR_TIMEOUT`, `ERR_OVERRUN`, `ERR_NO_FRAME`.
  - The state encoding.
- **Sub-module `shoot_sync`:** 2-FF synchronizer plus rising-edge pulse. It is reused for any future asynchronous strobe.
- **Top-level:** the FSM, timeout counter and staging registers stay in `module_frame_receiver`. The parent instantiates `uart_rx` separately.

## Test plan
- Bytes 8'hAB, then 8'hC1, with `MODULE_ID`=1, then a 3-cycle `shoot` pulse -> `sin_index`=12'hABC and `frame_id`=1. `index_valid` pulses once, exactly 3 cycles after `shoot` is sampled high.
- Bytes 8'h12, 8'h35 (ID 5, not ours), then `shoot` -> no update and `frame_error` with code 3. Repeat with 8'h3F (broadcast) -> `sin_index`=12'h123.
- Byte 8'h12, then idle for `BYTE_TIMEOUT` cycles -> error 1, back in WAIT_HI. A later 8'h45/8'h61 plus `shoot` -> `sin_index`=12'h456.
- Second byte arrives with `parity_error`=1 -> error 0, no staging. `shoot` then yields error 3.
- Frame 8'h11/8'h21 staged, then 8'h22/8'h31 with no `shoot` -> error 2 on byte 8'h22. `shoot` then commits 12'h223.
- `shoot` edge and the byte 8'h7F `rx_done` in the same cycle while PENDING (staged 12'hABC) -> commit 12'hABC, no error, `hi_q`=8'h7F, state WAIT_LO. Also assert `reset` in WAIT_LO -> all outputs return to 0 next cycle.
